lb_hub: RTL and testbench



---
 rtl/lb_hub_pkg.sv | 23 ++
 rtl/lb_hub_if.sv | 21 ++
 rtl/lb_hub_regs.sv | 87 ++++++++
 rtl/lb_hub.sv | 222 ++++++++++++++++++++++
 tb/tb_lb_hub.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lb_hub_pkg.sv
// Shared types and constants for the local-bus hub: FSM states, local
// register offsets, region field width and fixed response words.
package lb_hub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam int unsigned REGION_W = 4;

   localparam logic [15:0] OFS_ID        = 16'h0000;
   localparam logic [15:0] OFS_SCRATCH   = 16'h0004;
   localparam logic [15:0] OFS_USER_CTRL = 16'h0008;
   localparam logic [15:0] OFS_LED       = 16'h000C;
   localparam logic [15:0] OFS_STATUS    = 16'h0010;

   localparam logic [31:0] UNMAPPED_DATA = 32'hBADADD00;
   localparam logic [31:0] TIMEOUT_DATA  = 32'hDEADBEEF;

endpackage

// File: rtl/lb_hub_if.sv
// Host-side local bus: one-cycle strobes in, registered read data out.
interface lb_hub_if;

   logic        lb_wr;
   logic        lb_rd;
   logic [31:0] lb_addr;
   logic [31:0] lb_wr_d;
   logic [31:0] lb_rd_d;
   logic        lb_rd_rdy;

   modport master (
      output lb_wr, lb_rd, lb_addr, lb_wr_d,
      input  lb_rd_d, lb_rd_rdy
   );

   modport slave (
      input  lb_wr, lb_rd, lb_addr, lb_wr_d,
      output lb_rd_d, lb_rd_rdy
   );

endinterface

// File: rtl/lb_hub_regs.sv
// Local register file of the hub (region 0) and its combinational read mux.
// Optional feature macro: LB_HUB_TIMEOUT_EN (saturating timeout count in status).
module lb_hub_regs
   import lb_hub_pkg::*;
#(
   parameter logic [31:0] ID_VALUE = 32'h12345678
) (
   input  logic        clk_lb,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [15:0] addr,
   input  logic [31:0] wr_d,
`ifdef LB_HUB_TIMEOUT_EN
   input  logic        tmo_inc,
`endif
   input  logic        drop_set,
   output logic [31:0] rd_data,
   output logic [31:0] user_ctrl,
   output logic [3:0]  led_bus
);

   logic [31:0] scratch_q;
   logic [31:0] user_q;
   logic [3:0]  led_q;
   logic        drop_q;
   logic [31:0] status_val;

   // RW registers and sticky drop flag; a drop in the same cycle as a
   // status clear leaves the flag set
   always_ff @(posedge clk_lb) begin
      if (reset) begin
         scratch_q <= '0;
         user_q    <= '0;
         led_q     <= '0;
         drop_q    <= 1'b0;
      end else begin
         if (wr_en) begin
            case (addr)
               OFS_SCRATCH:   scratch_q <= wr_d;
               OFS_USER_CTRL: user_q    <= wr_d;
               OFS_LED:       led_q     <= wr_d[3:0];
               OFS_STATUS:    drop_q    <= 1'b0;
               default:       ;
            endcase
         end
         if (drop_set) begin
            drop_q <= 1'b1;
         end
      end
   end

`ifdef LB_HUB_TIMEOUT_EN
   logic [15:0] tmo_cnt_q;

   // Saturating count of abandoned slave reads, cleared by any status write
   always_ff @(posedge clk_lb) begin
      if (reset) begin
         tmo_cnt_q <= '0;
      end else if (wr_en && addr == OFS_STATUS) begin
         tmo_cnt_q <= '0;
      end else if (tmo_inc && tmo_cnt_q != 16'hFFFF) begin
         tmo_cnt_q <= tmo_cnt_q + 16'd1;
      end
   end

   assign status_val = {drop_q, 15'b0, tmo_cnt_q};
`else
   assign status_val = {drop_q, 31'b0};
`endif

   // Local read mux; unknown offsets read as zero
   always_comb begin
      rd_data = '0;
      case (addr)
         OFS_ID:        rd_data = ID_VALUE;
         OFS_SCRATCH:   rd_data = scratch_q;
         OFS_USER_CTRL: rd_data = user_q;
         OFS_LED:       rd_data = {28'b0, led_q};
         OFS_STATUS:    rd_data = status_val;
         default:       rd_data = '0;
      endcase
   end

   assign user_ctrl = user_q;
   assign led_bus   = led_q;

endmodule

// File: rtl/lb_hub.sv
// Local-bus hub: decodes region 0 to the local register file, regions
// 1..NUM_SLAVES to registered slave strobes, and runs the slave read FSM.
// Optional feature macro: LB_HUB_TIMEOUT_EN (abandon slave reads after
// RD_TIMEOUT cycles in WAIT).
module lb_hub
   import lb_hub_pkg::*;
#(
   parameter int unsigned NUM_SLAVES = 4,
   parameter int unsigned RD_TIMEOUT = 256,
   parameter logic [31:0] ID_VALUE   = 32'h12345678
) (
   input  logic                     clk_lb,
   input  logic                     reset,
   lb_hub_if.slave                  lb,
   output logic [NUM_SLAVES-1:0]    slv_cs,
   output logic                     slv_wr,
   output logic                     slv_rd,
   output logic [15:0]              slv_addr,
   output logic [31:0]              slv_wr_d,
   input  logic [NUM_SLAVES*32-1:0] slv_rd_d,
   input  logic [NUM_SLAVES-1:0]    slv_rd_rdy,
   output logic [31:0]              user_ctrl,
   output logic [3:0]               led_bus,
   output logic                     busy
);

   if (NUM_SLAVES < 1 || NUM_SLAVES > 15) begin : g_bad_num_slaves
      $error("lb_hub: NUM_SLAVES must be within 1..15");
   end
   if (RD_TIMEOUT < 2) begin : g_bad_rd_timeout
      $error("lb_hub: RD_TIMEOUT must be at least 2");
   end

   localparam logic [REGION_W-1:0] MAX_REGION = REGION_W'(NUM_SLAVES);

   state_t                state_q, state_n;
   logic [REGION_W-1:0]   sel_q, sel_n;
   logic [NUM_SLAVES-1:0] cs_q, cs_n;
   logic                  swr_q, swr_n;
   logic                  srd_q, srd_n;
   logic [15:0]           saddr_q, saddr_n;
   logic [31:0]           swd_q, swd_n;
   logic                  rdy_q, rdy_n;
   logic [31:0]           rd_d_q, rd_d_n;

   logic [REGION_W-1:0]   region;
   logic [15:0]           offset;
   logic                  idle, is_local, is_slave;
   logic [NUM_SLAVES-1:0] dec_cs;
   logic                  sel_rdy;
   logic [31:0]           sel_data;
   logic [31:0]           local_rd_d;
   logic                  local_wr, drop_set;

`ifdef LB_HUB_TIMEOUT_EN
   localparam int unsigned        CNT_W    = $clog2(RD_TIMEOUT);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
   logic [CNT_W-1:0]              wait_cnt_q, wait_cnt_n;
   logic                          tmo_inc;
`endif

   assign region   = lb.lb_addr[19:16];
   assign offset   = lb.lb_addr[15:0];
   assign idle     = (state_q == ST_IDLE);
   assign busy     = ~idle;
   assign is_local = (region == '0);
   assign is_slave = ~is_local && (region <= MAX_REGION);
   assign local_wr = idle & lb.lb_wr & is_local;
   // Strobes while busy are dropped; a read paired with a write loses
   assign drop_set = ((lb.lb_wr | lb.lb_rd) & ~idle) | (idle & lb.lb_wr & lb.lb_rd);

   // One-hot slave select for the addressed region and selected-slave mux
   always_comb begin
      dec_cs   = '0;
      sel_rdy  = 1'b0;
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         dec_cs[i] = (region == REGION_W'(i + 1));
         if (sel_q == REGION_W'(i)) begin
            sel_rdy  = slv_rd_rdy[i];
            sel_data = slv_rd_d[i*32 +: 32];
         end
      end
   end

   lb_hub_regs #(
      .ID_VALUE (ID_VALUE)
   ) u_regs (
      .clk_lb    (clk_lb),
      .reset     (reset),
      .wr_en     (local_wr),
      .addr      (offset),
      .wr_d      (lb.lb_wr_d),
`ifdef LB_HUB_TIMEOUT_EN
      .tmo_inc   (tmo_inc),
`endif
      .drop_set  (drop_set),
      .rd_data   (local_rd_d),
      .user_ctrl (user_ctrl),
      .led_bus   (led_bus)
   );

   // Next state and next values of all registered bus outputs
   always_comb begin
      state_n = state_q;
      sel_n   = sel_q;
      cs_n    = '0;
      swr_n   = 1'b0;
      srd_n   = 1'b0;
      saddr_n = saddr_q;
      swd_n   = swd_q;
      rdy_n   = 1'b0;
      rd_d_n  = rd_d_q;
`ifdef LB_HUB_TIMEOUT_EN
      wait_cnt_n = wait_cnt_q;
      tmo_inc    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (lb.lb_wr) begin
               if (is_slave) begin
                  cs_n    = dec_cs;
                  swr_n   = 1'b1;
                  saddr_n = offset;
                  swd_n   = lb.lb_wr_d;
               end
            end else if (lb.lb_rd) begin
               if (is_slave) begin
                  cs_n    = dec_cs;
                  srd_n   = 1'b1;
                  saddr_n = offset;
                  sel_n   = region - REGION_W'(1);
                  state_n = ST_ISSUE;
               end else begin
                  rdy_n  = 1'b1;
                  rd_d_n = is_local ? local_rd_d : UNMAPPED_DATA;
               end
            end
         end
         ST_ISSUE: begin
`ifdef LB_HUB_TIMEOUT_EN
            wait_cnt_n = '0;
`endif
            if (sel_rdy) begin
               rd_d_n  = sel_data;
               rdy_n   = 1'b1;
               state_n = ST_RESP;
            end else begin
               state_n = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (sel_rdy) begin
               rd_d_n  = sel_data;
               rdy_n   = 1'b1;
               state_n = ST_RESP;
            end
`ifdef LB_HUB_TIMEOUT_EN
            else if (wait_cnt_q == CNT_LAST) begin
               rd_d_n  = TIMEOUT_DATA;
               rdy_n   = 1'b1;
               tmo_inc = 1'b1;
               state_n = ST_RESP;
            end else begin
               wait_cnt_n = wait_cnt_q + CNT_W'(1);
            end
`endif
         end
         ST_RESP: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk_lb) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         cs_q    <= '0;
         swr_q   <= 1'b0;
         srd_q   <= 1'b0;
         saddr_q <= '0;
         swd_q   <= '0;
         rdy_q   <= 1'b0;
         rd_d_q  <= '0;
      end else begin
         state_q <= state_n;
         sel_q   <= sel_n;
         cs_q    <= cs_n;
         swr_q   <= swr_n;
         srd_q   <= srd_n;
         saddr_q <= saddr_n;
         swd_q   <= swd_n;
         rdy_q   <= rdy_n;
         rd_d_q  <= rd_d_n;
      end
   end

`ifdef LB_HUB_TIMEOUT_EN
   // Cycles spent in WAIT for the current slave read
   always_ff @(posedge clk_lb) begin
      if (reset) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_n;
      end
   end
`endif

   assign slv_cs       = cs_q;
   assign slv_wr       = swr_q;
   assign slv_rd       = srd_q;
   assign slv_addr     = saddr_q;
   assign slv_wr_d     = swd_q;
   assign lb.lb_rd_rdy = rdy_q;
   assign lb.lb_rd_d   = rd_d_q;

endmodule

// File: tb/tb_lb_hub.sv
// Randomized self-checking bench for lb_hub against a register-level model.
// Expectations follow LB_HUB_TIMEOUT_EN when it is defined for the build.
module tb_lb_hub;

   localparam int unsigned NS  = 4;
   localparam int unsigned RT  = 256;
   localparam logic [31:0] IDV = 32'h12345678;
`ifdef LB_HUB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic              clk_lb = 1'b0;
   logic              reset;
   lb_hub_if          lb();
   logic [NS-1:0]     slv_cs;
   logic              slv_wr, slv_rd;
   logic [15:0]       slv_addr;
   logic [31:0]       slv_wr_d;
   logic [NS*32-1:0]  slv_rd_d;
   logic [NS-1:0]     slv_rd_rdy;
   logic [31:0]       user_ctrl;
   logic [3:0]        led_bus;
   logic              busy;

   int checks = 0;
   int errors = 0;

   // Model of the local register file
   logic [31:0] m_scratch, m_user;
   logic [3:0]  m_led;
   logic        m_drop;
   logic [15:0] m_tmo;

   logic [15:0] offs [7] = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014, 16'h0100};

   always #5 clk_lb = ~clk_lb;

   lb_hub #(
      .NUM_SLAVES (NS),
      .RD_TIMEOUT (RT),
      .ID_VALUE   (IDV)
   ) dut (
      .clk_lb     (clk_lb),
      .reset      (reset),
      .lb         (lb),
      .slv_cs     (slv_cs),
      .slv_wr     (slv_wr),
      .slv_rd     (slv_rd),
      .slv_addr   (slv_addr),
      .slv_wr_d   (slv_wr_d),
      .slv_rd_d   (slv_rd_d),
      .slv_rd_rdy (slv_rd_rdy),
      .user_ctrl  (user_ctrl),
      .led_bus    (led_bus),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_scratch = '0; m_user = '0; m_led = '0; m_drop = 1'b0; m_tmo = '0;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [3:0] r;
      r = a[19:16];
      if (r != 0) return 32'hBADADD00;
      case (a[15:0])
         16'h0000: return IDV;
         16'h0004: return m_scratch;
         16'h0008: return m_user;
         16'h000C: return {28'b0, m_led};
         16'h0010: return {m_drop, 15'b0, (TMO_EN ? m_tmo : 16'h0000)};
         default:  return 32'h0;
      endcase
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
      if (a[19:16] != 0) return;
      case (a[15:0])
         16'h0004: m_scratch = d;
         16'h0008: m_user    = d;
         16'h000C: m_led     = d[3:0];
         16'h0010: begin m_drop = 1'b0; m_tmo = '0; end
         default: ;
      endcase
   endfunction

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      logic [3:0] r;
      r = a[19:16];
      lb.lb_addr = a; lb.lb_wr_d = d; lb.lb_wr = 1'b1;
      @(negedge clk_lb);
      lb.lb_wr = 1'b0;
      if (r >= 1 && r <= NS) begin
         check("swr_strobe", 32'(slv_wr), 32'd1);
         check("swr_cs", 32'(slv_cs), 32'd1 << (r - 1));
         check("swr_addr", 32'(slv_addr), 32'(a[15:0]));
         check("swr_data", slv_wr_d, d);
         @(negedge clk_lb);
         check("swr_pulse", 32'({slv_wr, slv_cs}), 32'd0);
      end else begin
         check("wr_no_strobe", 32'({slv_wr, slv_rd, slv_cs}), 32'd0);
         model_write(a, d);
         check("user_ctrl", user_ctrl, m_user);
         check("led_bus", 32'(led_bus), 32'(m_led));
      end
      check("wr_busy", 32'(busy), 32'd0);
   endtask

   task automatic do_read(input logic [31:0] a);
      lb.lb_addr = a; lb.lb_rd = 1'b1;
      @(negedge clk_lb);
      lb.lb_rd = 1'b0;
      check("rd_rdy", 32'(lb.lb_rd_rdy), 32'd1);
      check("rd_data", lb.lb_rd_d, model_read(a));
      check("rd_no_slave", 32'({slv_rd, slv_cs}), 32'd0);
   endtask

   task automatic do_wr_rd(input logic [31:0] a, input logic [31:0] d);
      lb.lb_addr = a; lb.lb_wr_d = d; lb.lb_wr = 1'b1; lb.lb_rd = 1'b1;
      @(negedge clk_lb);
      lb.lb_wr = 1'b0; lb.lb_rd = 1'b0;
      model_write(a, d);
      m_drop = 1'b1;
      check("wrrd_no_rdy", 32'(lb.lb_rd_rdy), 32'd0);
      check("wrrd_user", user_ctrl, m_user);
   endtask

   // Slave read; the selected slave answers L cycles after slv_rd (0 = same cycle)
   task automatic do_slave_read(input logic [31:0] a, input int unsigned lat,
                                input logic [31:0] data, input bit poke);
      int unsigned idx, s, exp_s;
      bit got, saw, tmo;
      idx = 32'(a[19:16]) - 1;
      s = 1; got = 1'b0; saw = 1'b0;
      tmo = TMO_EN && (lat > RT);
      exp_s = tmo ? RT + 2 : lat + 2;
      lb.lb_addr = a; lb.lb_rd = 1'b1;
      @(negedge clk_lb);
      lb.lb_rd = 1'b0;
      check("srd_strobe", 32'(slv_rd), 32'd1);
      check("srd_cs", 32'(slv_cs), 32'd1 << idx);
      check("srd_addr", 32'(slv_addr), 32'(a[15:0]));
      check("srd_busy", 32'(busy), 32'd1);
      while (!got && s < exp_s + 8) begin
         slv_rd_rdy = '0; lb.lb_wr = 1'b0; lb.lb_rd = 1'b0;
         for (int i = 0; i < NS; i++) begin
            if (i != int'(idx) && $urandom_range(0, 3) == 0) begin
               slv_rd_rdy[i] = 1'b1;
               slv_rd_d[i*32 +: 32] = $urandom;
            end
         end
         if (s == lat + 1) begin
            slv_rd_rdy[idx] = 1'b1;
            slv_rd_d[idx*32 +: 32] = data;
         end
         if (poke && s == 2) begin
            lb.lb_addr = 32'h0001_0000; lb.lb_wr_d = $urandom;
            if ($urandom_range(0, 1) == 1) lb.lb_wr = 1'b1; else lb.lb_rd = 1'b1;
            m_drop = 1'b1;
         end
         @(negedge clk_lb);
         s++;
         if (slv_wr || slv_rd) saw = 1'b1;
         got = lb.lb_rd_rdy;
      end
      slv_rd_rdy = '0; lb.lb_wr = 1'b0; lb.lb_rd = 1'b0;
      check("srd_latency", s, exp_s);
      check("srd_data", lb.lb_rd_d, tmo ? 32'hDEADBEEF : data);
      check("srd_no_fwd", 32'(saw), 32'd0);
      if (tmo && m_tmo != 16'hFFFF) m_tmo++;
      @(negedge clk_lb);
      check("srd_pulse", 32'({lb.lb_rd_rdy, busy}), 32'd0);
   endtask

   function automatic logic [31:0] rand_local();
      return {16'h0000, offs[$urandom_range(0, 6)]};
   endfunction

   function automatic logic [31:0] rand_slave();
      logic [3:0] r;
      r = 4'($urandom_range(1, NS));
      return {12'h000, r, 16'($urandom)};
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      lb.lb_wr = 1'b0; lb.lb_rd = 1'b0; lb.lb_addr = '0; lb.lb_wr_d = '0;
      slv_rd_d = '0; slv_rd_rdy = '0;
      reset = 1'b1;
      model_reset();
      repeat (3) @(negedge clk_lb);
      reset = 1'b0;
      @(negedge clk_lb);

      check("rst_outs", 32'({lb.lb_rd_rdy, busy, slv_cs, slv_wr, slv_rd}), 32'd0);
      check("rst_user", user_ctrl, 32'd0);
      check("rst_led", 32'(led_bus), 32'd0);
      do_read(32'h0000_0010);
      do_read(32'h0000_0004);

      do_write(32'h0000_0004, 32'hA5A5A5A5);
      do_read(32'h0000_0004);
      do_read(32'h0000_0000);

      do_slave_read(32'h0002_0010, 5, 32'hCAFE0001, 1'b0);
      do_read(32'h0000_0010);

      for (int k = 0; k < 4; k++) begin
         do_slave_read(32'h0003_0000, RT + 40, 32'h5100_0000 + 32'(k), 1'b0);
         do_read(32'h0000_0010);
      end

      do_slave_read(32'h0004_0100, RT, 32'h0BAD_F00D, 1'b0);
      do_slave_read(32'h0001_0200, RT - 1, 32'h1234_0000, 1'b0);
      do_slave_read(32'h0001_0300, 0, 32'h0000_ABCD, 1'b0);
      do_read(32'h0000_0010);

      do_read(32'h000F_0000);
      do_slave_read(32'h0002_0040, 6, 32'h7777_0001, 1'b1);
      do_read(32'h0000_0010);
      do_write(32'h0000_0010, 32'hFFFF_FFFF);
      do_read(32'h0000_0010);

      do_wr_rd(32'h0000_0008, 32'h0F0F_1234);
      do_read(32'h0000_0008);
      do_read(32'h0000_0010);

      do_write(32'h0000_000C, 32'h0000_0009);
      lb.lb_addr = 32'h0001_0040; lb.lb_rd = 1'b1;
      @(negedge clk_lb);
      lb.lb_rd = 1'b0;
      repeat (3) @(negedge clk_lb);
      reset = 1'b1;
      @(negedge clk_lb);
      reset = 1'b0;
      model_reset();
      check("rstw_outs", 32'({lb.lb_rd_rdy, busy, slv_cs, slv_wr, slv_rd}), 32'd0);
      check("rstw_addr", 32'(slv_addr), 32'd0);
      check("rstw_wrd", slv_wr_d, 32'd0);
      check("rstw_rdd", lb.lb_rd_d, 32'd0);
      check("rstw_user", user_ctrl, 32'd0);
      check("rstw_led", 32'(led_bus), 32'd0);
      slv_rd_rdy[0] = 1'b1; slv_rd_d[31:0] = 32'h1A7E_0000;
      @(negedge clk_lb);
      slv_rd_rdy = '0;
      for (int k = 0; k < 3; k++) begin
         check("rstw_late_rdy", 32'({lb.lb_rd_rdy, busy}), 32'd0);
         @(negedge clk_lb);
      end
      do_read(32'h0000_0000);
      do_read(32'h0000_0004);

      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 5))
            0: do_write(rand_local(), $urandom);
            1: do_read(rand_local());
            2: begin
               if ($urandom_range(0, 1) == 1)
                  do_read({12'h000, 4'($urandom_range(NS + 1, 15)), 16'($urandom)});
               else
                  do_write({12'h000, 4'($urandom_range(NS + 1, 15)), 16'($urandom)}, $urandom);
            end
            3: do_write(rand_slave(), $urandom);
            4: do_slave_read(rand_slave(), $urandom_range(0, 12), $urandom,
                             $urandom_range(0, 3) == 0);
            default: do_wr_rd({16'h0000, offs[$urandom_range(1, 5)]}, $urandom);
         endcase
      end
      do_read(32'h0000_0010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
